// File: rtl/wb_stage_mp.sv
// Write-back pipeline stage with several register-file write channels.
// Registers the MEM->WB bundle under the global stall vector. It derives
// effective byte enables: valid gating, zero-register masking, and
// lower-index-wins collision arbitration. It also counts retired instructions.

`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

module wb_stage_mp #(
    parameter int                NUM_WP    = 2,
    parameter int                DW        = 32,
    parameter int                AW        = 5,
    parameter int                PCW       = 32,
    parameter int                STALL_IDX = 4,
    parameter logic [NUM_WP-1:0] ZERO_MASK = NUM_WP'(1'b1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [`StallBus]                     stall,
    input  logic [1+PCW+NUM_WP*(DW/8+AW+DW)-1:0] mem_to_wb_bus,
    output logic [NUM_WP*(DW/8+AW+DW)-1:0]       wb_to_rf_bus,
    output logic                                 wb_valid,
    output logic [PCW-1:0]                       debug_wb_pc,
    output logic [DW/8-1:0]                      debug_wb_rf_wen,
    output logic [AW-1:0]                        debug_wb_rf_wnum,
    output logic [DW-1:0]                        debug_wb_rf_wdata,
    output logic [63:0]                          retire_cnt,
    output logic                                 wb_collision
);

    localparam int BEW  = DW / 8;
    localparam int CHW  = BEW + AW + DW;
    localparam int BUSW = 1 + PCW + NUM_WP * CHW;

    logic [BUSW-1:0] bundle_q;
    logic [BUSW-1:0] bundle_d;
    logic [63:0]     retire_cnt_q;
    logic [63:0]     retire_cnt_d;
    logic            collision_q;
    logic            collision_d;

    logic              valid_s;
    logic [PCW-1:0]    pc_s;
    logic [BEW-1:0]    wen_s     [NUM_WP];
    logic [AW-1:0]     waddr_s   [NUM_WP];
    logic [DW-1:0]     wdata_s   [NUM_WP];
    logic [BEW-1:0]    pre_wen_s [NUM_WP];
    logic [BEW-1:0]    eff_wen_s [NUM_WP];
    logic [NUM_WP-1:0] lose_s;
    logic              collision_s;
    logic              retire_s;
    logic              unused_stall_s;

    // Only two bits of the global stall vector concern this stage.
    assign unused_stall_s = ^stall;

    // Next bundle: flush beats stall; own stall with free downstream makes a bubble.
    always_comb begin
        bundle_d = bundle_q;
        if (flush) begin
            bundle_d = '0;
        end else if ((stall[STALL_IDX] == `Stop) && (stall[STALL_IDX+1] == `NoStop)) begin
            bundle_d = '0;
        end else if (stall[STALL_IDX] == `NoStop) begin
            bundle_d = mem_to_wb_bus;
        end else begin
            bundle_d = bundle_q;
        end
    end

    // Unpack the registered bundle into per-channel fields.
    always_comb begin
        valid_s = bundle_q[BUSW-1];
        pc_s    = bundle_q[BUSW-2 -: PCW];
        for (int p = 0; p < NUM_WP; p++) begin
            wdata_s[p] = bundle_q[p*CHW +: DW];
            waddr_s[p] = bundle_q[p*CHW+DW +: AW];
            wen_s[p]   = bundle_q[p*CHW+DW+AW +: BEW];
        end
    end

    // Effective enables: valid gating, zero-register mask, then arbitration.
    // Arbitration compares post-mask enables, so a masked write never collides.
    always_comb begin
        lose_s      = '0;
        collision_s = 1'b0;
        for (int p = 0; p < NUM_WP; p++) begin
            pre_wen_s[p] = (ZERO_MASK[p] && (waddr_s[p] == {AW{1'b0}})) ?
                           {BEW{1'b0}} : (wen_s[p] & {BEW{valid_s}});
        end
        for (int q = 1; q < NUM_WP; q++) begin
            for (int p = 0; p < q; p++) begin
                lose_s[q]   = lose_s[q] |
                              ((pre_wen_s[p] != {BEW{1'b0}}) &&
                               (pre_wen_s[q] != {BEW{1'b0}}) &&
                               (waddr_s[p] == waddr_s[q]));
                collision_s = collision_s | lose_s[q];
            end
        end
        for (int p = 0; p < NUM_WP; p++) begin
            eff_wen_s[p] = lose_s[p] ? {BEW{1'b0}} : pre_wen_s[p];
        end
    end

    // Retire counter and sticky collision flag; the count happens as a bundle leaves.
    always_comb begin
        retire_s = valid_s && (stall[STALL_IDX+1] == `NoStop);
        if (retire_s) begin
            retire_cnt_d = retire_cnt_q + 64'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
        collision_d = collision_q | collision_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q     <= '0;
            retire_cnt_q <= 64'd0;
            collision_q  <= 1'b0;
        end else begin
            bundle_q     <= bundle_d;
            retire_cnt_q <= retire_cnt_d;
            collision_q  <= collision_d;
        end
    end

    // Output drive, derived from registered state only.
    always_comb begin
        wb_to_rf_bus = '0;
        for (int p = 0; p < NUM_WP; p++) begin
            wb_to_rf_bus[p*CHW +: CHW] = {eff_wen_s[p], waddr_s[p], wdata_s[p]};
        end
        wb_valid          = valid_s;
        debug_wb_pc       = pc_s;
        debug_wb_rf_wen   = eff_wen_s[0];
        debug_wb_rf_wnum  = waddr_s[0];
        debug_wb_rf_wdata = wdata_s[0];
        retire_cnt        = retire_cnt_q;
        wb_collision      = collision_q;
    end

endmodule

// File: tb/tb_wb_stage_mp.sv
// Directed self-checking bench for wb_stage_mp (two channels, default parameters).
module tb_wb_stage_mp;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [5:0]    stall;
    logic [114:0]  mem_to_wb_bus;
    logic [81:0]   wb_to_rf_bus;
    logic          wb_valid;
    logic [31:0]   debug_wb_pc;
    logic [3:0]    debug_wb_rf_wen;
    logic [4:0]    debug_wb_rf_wnum;
    logic [31:0]   debug_wb_rf_wdata;
    logic [63:0]   retire_cnt;
    logic          wb_collision;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] ST_RUN    = 6'b000000;
    localparam logic [5:0] ST_BUBBLE = 6'b010000;
    localparam logic [5:0] ST_HOLD   = 6'b110000;

    wb_stage_mp dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .stall             (stall),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .wb_to_rf_bus      (wb_to_rf_bus),
        .wb_valid          (wb_valid),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .retire_cnt        (retire_cnt),
        .wb_collision      (wb_collision)
    );

    always #5 clk = ~clk;

    function automatic logic [114:0] mk(input logic v, input logic [31:0] pc,
                                        input logic [3:0] w0, input logic [4:0] a0, input logic [31:0] d0,
                                        input logic [3:0] w1, input logic [4:0] a1, input logic [31:0] d1);
        return {v, pc, w1, a1, d1, w0, a0, d0};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = ST_RUN;
        // Reset with garbage on the input
        for (int i = 0; i < 3; i++) begin
            mem_to_wb_bus = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        check("rst_valid", wb_valid, 1'b0);
        check("rst_pc", debug_wb_pc, 32'h0);
        check("rst_bus", wb_to_rf_bus, 82'h0);
        check("rst_retire", retire_cnt, 64'd0);
        check("rst_coll", wb_collision, 1'b0);

        // First real instruction
        rst = 1'b0;
        mem_to_wb_bus = mk(1'b1, 32'hBFC00000, 4'hF, 5'd8, 32'h12345678, 4'h0, 5'd0, 32'h0);
        step();
        check("a_valid", wb_valid, 1'b1);
        check("a_pc", debug_wb_pc, 32'hBFC00000);
        check("a_wen", debug_wb_rf_wen, 4'hF);
        check("a_wnum", debug_wb_rf_wnum, 5'd8);
        check("a_wdata", debug_wb_rf_wdata, 32'h12345678);
        check("a_retire0", retire_cnt, 64'd0);

        // Own stall, downstream free: bubbles, A counted as it leaves
        stall = ST_BUBBLE;
        mem_to_wb_bus = mk(1'b1, 32'hBFC00004, 4'hF, 5'd9, 32'h0000BBBB, 4'h0, 5'd0, 32'h0);
        step();
        check("bub1_valid", wb_valid, 1'b0);
        check("bub1_wen", debug_wb_rf_wen, 4'h0);
        check("bub1_retire", retire_cnt, 64'd1);
        step();
        check("bub2_valid", wb_valid, 1'b0);
        check("bub2_pc", debug_wb_pc, 32'h0);
        check("bub2_retire", retire_cnt, 64'd1);

        // Load B, then hold it while downstream is stalled
        stall = ST_RUN;
        step();
        check("b_pc", debug_wb_pc, 32'hBFC00004);
        check("b_retire", retire_cnt, 64'd1);
        stall = ST_HOLD;
        mem_to_wb_bus = mk(1'b1, 32'hBFC00008, 4'hF, 5'd10, 32'h0000CCCC, 4'h0, 5'd0, 32'h0);
        step();
        step();
        check("hold_pc", debug_wb_pc, 32'hBFC00004);
        check("hold_valid", wb_valid, 1'b1);
        check("hold_retire", retire_cnt, 64'd1);
        stall = ST_RUN;
        step();
        check("rel_pc", debug_wb_pc, 32'hBFC00008);
        check("rel_retire", retire_cnt, 64'd2);

        // Zero-register masking: ch0 masked, ch1 not
        mem_to_wb_bus = mk(1'b1, 32'hBFC0000C, 4'hF, 5'd0, 32'h0000DEAD, 4'hF, 5'd0, 32'h0000BEEF);
        step();
        check("zm_wen0", debug_wb_rf_wen, 4'h0);
        check("zm_bus", wb_to_rf_bus, {4'hF, 5'd0, 32'h0000BEEF, 4'h0, 5'd0, 32'h0000DEAD});
        check("zm_coll", wb_collision, 1'b0);
        check("zm_retire", retire_cnt, 64'd3);

        // Same-address collision: ch0 wins
        mem_to_wb_bus = mk(1'b1, 32'hBFC00010, 4'hF, 5'd3, 32'hAAAA0000, 4'hC, 5'd3, 32'h5555FFFF);
        step();
        check("col_wdata", debug_wb_rf_wdata, 32'hAAAA0000);
        check("col_wen0", debug_wb_rf_wen, 4'hF);
        check("col_bus", wb_to_rf_bus, {4'h0, 5'd3, 32'h5555FFFF, 4'hF, 5'd3, 32'hAAAA0000});

        // Flush with a valid input: bubble, flag stays, flushed bundle not counted
        flush = 1'b1;
        mem_to_wb_bus = mk(1'b1, 32'hBFC00014, 4'hF, 5'd4, 32'h44444444, 4'h0, 5'd0, 32'h0);
        step();
        check("fl_valid", wb_valid, 1'b0);
        check("fl_coll", wb_collision, 1'b1);
        check("fl_retire", retire_cnt, 64'd5);
        flush = 1'b0;
        mem_to_wb_bus = '0;
        step();
        check("fl2_retire", retire_cnt, 64'd5);
        check("fl2_coll", wb_collision, 1'b1);

        // Partial byte enables
        mem_to_wb_bus = mk(1'b1, 32'hBFC00018, 4'h3, 5'd7, 32'h11223344, 4'h0, 5'd0, 32'h0);
        step();
        check("pw_wen", debug_wb_rf_wen, 4'h3);

        // Reset in the middle of a downstream stall clears everything
        stall = ST_HOLD;
        rst = 1'b1;
        step();
        check("rst2_coll", wb_collision, 1'b0);
        check("rst2_retire", retire_cnt, 64'd0);
        check("rst2_valid", wb_valid, 1'b0);
        rst = 1'b0;
        stall = ST_RUN;

        // 2^16 consecutive valid bundles
        mem_to_wb_bus = mk(1'b1, 32'h80000000, 4'hF, 5'd1, 32'h1, 4'h0, 5'd0, 32'h0);
        for (int i = 0; i < 65536; i++) begin
            @(posedge clk);
        end
        #1;
        check("long_retire_m1", retire_cnt, 64'd65535);
        mem_to_wb_bus = '0;
        step();
        check("long_retire", retire_cnt, 64'd65536);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
